// File: rtl/d7s_scan_decoder.sv
// Seven-segment scan monitor: resolves the refreshed digit from the AN/D7S bus and decodes each glyph to a 5-bit code.
// Latency: 2 sync stages + STABLE_CYCLES hold; outputs update on the edge the hold count reaches STABLE_CYCLES-1.
// Backpressure: none; the bus is sampled passively every cycle and results are level outputs plus a frame_done pulse.
//
// Ports:
//   clk, reset_n      100 MHz clock, asynchronous active-low reset (synchronous release expected upstream)
//   an[7:0]           anode lines, active-low, bit i low selects digit i
//   d7s[6:0]          segment lines, active-low, bit0=a .. bit6=g
//   digit_code[39:0]  5-bit code of digit i in bits [5i+4:5i]
//   digit_valid[7:0]  digit i captured since reset or the last stale event
//   frame_done        one-cycle pulse once all 8 digits have been captured
//   anode_err         sticky: a stable pattern had more than one anode low
//   stale             no capture for TIMEOUT_CYCLES cycles, cleared by the next capture

module d7s_scan_decoder #(
    parameter int STABLE_CYCLES  = 16,
    parameter int TIMEOUT_CYCLES = 4000000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [7:0]  an,
    input  logic [6:0]  d7s,
    output logic [39:0] digit_code,
    output logic [7:0]  digit_valid,
    output logic        frame_done,
    output logic        anode_err,
    output logic        stale
);

    localparam int SW = $clog2(STABLE_CYCLES);
    localparam int TW = $clog2(TIMEOUT_CYCLES);

    localparam logic [SW-1:0] STABLE_MAX  = SW'(STABLE_CYCLES - 1);
    localparam logic [SW-1:0] STABLE_ARM  = SW'(STABLE_CYCLES - 2);
    localparam logic [TW-1:0] TIMEOUT_MAX = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] TIMEOUT_ARM = TW'(TIMEOUT_CYCLES - 2);

    localparam logic [4:0] CODE_BLANK   = 5'h10;
    localparam logic [4:0] CODE_UNKNOWN = 5'h1F;

    // Lit-segment set (1 = segment on, bit order g..a) to character code.
    function automatic logic [4:0] decode_glyph(input logic [6:0] lit);
        logic [4:0] code;
        case (lit)
            7'h3F:   code = 5'h00;
            7'h06:   code = 5'h01;
            7'h5B:   code = 5'h02;
            7'h4F:   code = 5'h03;
            7'h66:   code = 5'h04;
            7'h6D:   code = 5'h05;
            7'h7D:   code = 5'h06;
            7'h07:   code = 5'h07;
            7'h7F:   code = 5'h08;
            7'h6F:   code = 5'h09;
            7'h77:   code = 5'h0A;
            7'h7C:   code = 5'h0B;
            7'h39:   code = 5'h0C;
            7'h5E:   code = 5'h0D;
            7'h79:   code = 5'h0E;
            7'h71:   code = 5'h0F;
            7'h00:   code = CODE_BLANK;
            7'h76:   code = 5'h11;
            7'h54:   code = 5'h12;
            default: code = CODE_UNKNOWN;
        endcase
        return code;
    endfunction

    logic [7:0]    an_m;
    logic [7:0]    an_s;
    logic [6:0]    d7s_m;
    logic [6:0]    d7s_s;
    logic [14:0]   prev_s;
    logic [SW-1:0] stable_cnt;
    logic [TW-1:0] tmo_cnt;
    logic [7:0]    seen;

    logic [7:0]    an_low;
    logic          sample_same;
    logic          hold_done;
    logic          one_low;
    logic          multi_low;
    logic          capture;
    logic          tmo_hit;
    logic [7:0]    cap_mask;
    logic [4:0]    glyph;

    always_comb begin
        an_low      = ~an_s;
        sample_same = ({an_s, d7s_s} == prev_s);
        // Fires only on the step into STABLE_MAX, so a long hold yields a single capture.
        hold_done   = sample_same && (stable_cnt == STABLE_ARM);
        one_low     = $onehot(an_low);
        multi_low   = (an_low != 8'h00) && !one_low;
        capture     = hold_done && one_low;
        cap_mask    = capture ? an_low : 8'h00;
        // Capture in the same cycle takes priority over the timeout.
        tmo_hit     = !capture && (tmo_cnt == TIMEOUT_ARM);
        glyph       = decode_glyph(~d7s_s);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            an_m        <= 8'hFF;
            an_s        <= 8'hFF;
            d7s_m       <= 7'h7F;
            d7s_s       <= 7'h7F;
            prev_s      <= 15'h7FFF;
            stable_cnt  <= '0;
            tmo_cnt     <= '0;
            seen        <= 8'h00;
            digit_code  <= {8{CODE_BLANK}};
            digit_valid <= 8'h00;
            frame_done  <= 1'b0;
            anode_err   <= 1'b0;
            stale       <= 1'b0;
        end else begin
            an_m   <= an;
            an_s   <= an_m;
            d7s_m  <= d7s;
            d7s_s  <= d7s_m;
            prev_s <= {an_s, d7s_s};

            if (!sample_same) begin
                stable_cnt <= '0;
            end else if (stable_cnt != STABLE_MAX) begin
                stable_cnt <= stable_cnt + 1'b1;
            end

            if (capture) begin
                tmo_cnt <= '0;
            end else if (tmo_cnt != TIMEOUT_MAX) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end

            for (int i = 0; i < 8; i++) begin
                if (cap_mask[i]) begin
                    digit_code[5*i +: 5] <= glyph;
                end
            end

            if (capture) begin
                digit_valid <= digit_valid | cap_mask;
                stale       <= 1'b0;
            end else if (tmo_hit) begin
                digit_valid <= 8'h00;
                stale       <= 1'b1;
            end

            // A full seen mask is reported one edge after it forms and restarts
            // from whatever is captured on that edge.
            frame_done <= 1'b0;
            if (tmo_hit) begin
                seen <= 8'h00;
            end else if (seen == 8'hFF) begin
                frame_done <= 1'b1;
                seen       <= cap_mask;
            end else begin
                seen <= seen | cap_mask;
            end

            // Judged only on a settled pattern so anode crossover during a
            // driver's digit switch is not flagged.
            if (hold_done && multi_low) begin
                anode_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_d7s_scan_decoder.sv
module tb_d7s_scan_decoder;

    localparam int STABLE  = 16;
    localparam int TIMEOUT = 1000;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [7:0]  an = 8'hFF;
    logic [6:0]  d7s = 7'h7F;
    logic [39:0] digit_code;
    logic [7:0]  digit_valid;
    logic        frame_done;
    logic        anode_err;
    logic        stale;

    d7s_scan_decoder #(
        .STABLE_CYCLES (STABLE),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .an         (an),
        .d7s        (d7s),
        .digit_code (digit_code),
        .digit_valid(digit_valid),
        .frame_done (frame_done),
        .anode_err  (anode_err),
        .stale      (stale)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;
    int fd_count = 0;

    always @(negedge clk) begin
        if (frame_done === 1'b1) fd_count++;
    end

    typedef struct {
        logic [2:0] idx;
        logic [6:0] lit;
        logic [4:0] code;
    } vec_t;

    vec_t vecs[20];

    task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        an = 8'hFF;
        d7s = 7'h7F;
        cyc(3);
        reset_n = 1'b1;
        cyc(3);
    endtask

    task automatic scan_digit(input int idx, input logic [6:0] lit, input int hold);
        logic [7:0] sel;
        sel = 8'h01 << idx;
        an  = ~sel;
        d7s = ~lit;
        cyc(hold);
    endtask

    task automatic idle(input int n);
        an  = 8'hFF;
        d7s = 7'h7F;
        cyc(n);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_code"},  digit_code,  {8{5'h10}});
        check({tag, "_valid"}, {32'h0, digit_valid}, 40'h0);
        check({tag, "_fd"},    {39'h0, frame_done}, 40'h0);
        check({tag, "_err"},   {39'h0, anode_err},  40'h0);
        check({tag, "_stale"}, {39'h0, stale},      40'h0);
    endtask

    initial begin
        int fd_before;
        logic [7:0] sel;

        vecs[0]  = '{3'd0, 7'h3F, 5'h00};
        vecs[1]  = '{3'd1, 7'h06, 5'h01};
        vecs[2]  = '{3'd2, 7'h5B, 5'h02};
        vecs[3]  = '{3'd3, 7'h4F, 5'h03};
        vecs[4]  = '{3'd4, 7'h66, 5'h04};
        vecs[5]  = '{3'd5, 7'h6D, 5'h05};
        vecs[6]  = '{3'd6, 7'h7D, 5'h06};
        vecs[7]  = '{3'd7, 7'h07, 5'h07};
        vecs[8]  = '{3'd0, 7'h7F, 5'h08};
        vecs[9]  = '{3'd1, 7'h6F, 5'h09};
        vecs[10] = '{3'd2, 7'h77, 5'h0A};
        vecs[11] = '{3'd3, 7'h7C, 5'h0B};
        vecs[12] = '{3'd4, 7'h39, 5'h0C};
        vecs[13] = '{3'd5, 7'h5E, 5'h0D};
        vecs[14] = '{3'd6, 7'h79, 5'h0E};
        vecs[15] = '{3'd7, 7'h71, 5'h0F};
        vecs[16] = '{3'd0, 7'h00, 5'h10};
        vecs[17] = '{3'd1, 7'h76, 5'h11};
        vecs[18] = '{3'd2, 7'h54, 5'h12};
        vecs[19] = '{3'd3, 7'h09, 5'h1F};

        // Reset values
        do_reset();
        check_reset_outputs("reset");

        // Single digit: not yet captured before the sync+hold latency, captured by 40 cycles
        scan_digit(0, 7'h3F, STABLE - 1);
        check("single_early_valid", {32'h0, digit_valid}, 40'h0);
        cyc(40 - (STABLE - 1));
        check("single_valid", {32'h0, digit_valid}, 40'h01);
        check("single_code",  {35'h0, digit_code[4:0]}, 40'h00);
        check("single_fd",    fd_count, 0);

        // Glyph decode table
        for (int v = 0; v < 20; v++) begin
            scan_digit(vecs[v].idx, vecs[v].lit, 40);
            check($sformatf("vec%0d_code", v), {35'h0, digit_code[5*vecs[v].idx +: 5]}, {35'h0, vecs[v].code});
            check($sformatf("vec%0d_valid", v), {39'h0, digit_valid[vecs[v].idx]}, 40'h1);
        end
        idle(10);

        // Full frame, two scans
        do_reset();
        fd_before = fd_count;
        scan_digit(0, 7'h6F, 200);
        scan_digit(1, 7'h5E, 200);
        scan_digit(2, 7'h00, 200);
        scan_digit(3, 7'h76, 200);
        scan_digit(4, 7'h54, 200);
        scan_digit(5, 7'h00, 200);
        scan_digit(6, 7'h76, 200);
        check("frame_no_early_fd", fd_count - fd_before, 0);
        scan_digit(7, 7'h7C, 200);
        check("frame1_fd", fd_count - fd_before, 1);
        check("frame_code", digit_code, {5'h0B, 5'h11, 5'h10, 5'h12, 5'h11, 5'h10, 5'h0D, 5'h09});
        check("frame_valid", {32'h0, digit_valid}, 40'hFF);
        scan_digit(0, 7'h6F, 200);
        scan_digit(1, 7'h5E, 200);
        scan_digit(2, 7'h00, 200);
        scan_digit(3, 7'h76, 200);
        scan_digit(4, 7'h54, 200);
        scan_digit(5, 7'h00, 200);
        scan_digit(6, 7'h76, 200);
        scan_digit(7, 7'h7C, 200);
        check("frame2_fd", fd_count - fd_before, 2);
        idle(10);

        // Glitch rejection
        do_reset();
        scan_digit(0, 7'h06, STABLE - 3);
        idle(40);
        check("short_hold_valid", {32'h0, digit_valid}, 40'h0);
        scan_digit(1, 7'h5B, STABLE - 4);
        scan_digit(1, 7'h5A, 1);
        scan_digit(1, 7'h5B, STABLE - 4);
        idle(40);
        check("seg_glitch_valid", {32'h0, digit_valid}, 40'h0);
        scan_digit(1, 7'h5B, 40);
        check("after_glitch_valid", {32'h0, digit_valid}, 40'h02);
        check("after_glitch_code", {35'h0, digit_code[9:5]}, 40'h02);

        // Anode error
        do_reset();
        an  = 8'hFC;
        d7s = ~7'h7F;
        cyc(40);
        check("anerr_set",   {39'h0, anode_err}, 40'h1);
        check("anerr_valid", {32'h0, digit_valid}, 40'h0);
        scan_digit(3, 7'h4F, 40);
        check("anerr_sticky", {39'h0, anode_err}, 40'h1);
        check("anerr_scan_valid", {32'h0, digit_valid}, 40'h08);
        do_reset();
        check("anerr_cleared", {39'h0, anode_err}, 40'h0);

        // Timeout and stale
        scan_digit(0, 7'h3F, 40);
        idle(800);
        check("tmo_early_stale", {39'h0, stale}, 40'h0);
        check("tmo_early_valid", {32'h0, digit_valid}, 40'h01);
        cyc(300);
        check("tmo_stale", {39'h0, stale}, 40'h1);
        check("tmo_valid", {32'h0, digit_valid}, 40'h0);
        check("tmo_code_kept", {35'h0, digit_code[4:0]}, 40'h00);
        scan_digit(1, 7'h06, 40);
        check("tmo_recover_stale", {39'h0, stale}, 40'h0);
        check("tmo_recover_valid", {32'h0, digit_valid}, 40'h02);
        idle(10);

        // Async reset mid-frame
        do_reset();
        for (int d = 0; d < 4; d++) scan_digit(d, 7'h7F, 40);
        check("pre_areset_valid", {32'h0, digit_valid}, 40'h0F);
        #2 reset_n = 1'b0;
        #1 check_reset_outputs("areset");
        @(negedge clk);
        reset_n = 1'b1;
        fd_before = fd_count;
        for (int d = 4; d < 8; d++) scan_digit(d, 7'h7F, 40);
        check("areset_no_fd", fd_count - fd_before, 0);
        for (int d = 0; d < 4; d++) scan_digit(d, 7'h7F, 40);
        check("areset_new_frame_fd", fd_count - fd_before, 1);
        idle(5);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
